// File: rtl/io_debounce_bit.sv
// One conditioned input bit: two-flop synchroniser, stability counter,
// debounced level and one-cycle rise/fall pulses.
module io_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit RESET_PIN_LEVEL = 1'b0,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             synced;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1 <= RESET_PIN_LEVEL;
            sync_q2 <= RESET_PIN_LEVEL;
        end else begin
            sync_q1 <= pin_i;
            sync_q2 <= sync_q1;
        end
    end

    // Everything past the synchroniser is active-high.
    assign synced = sync_q2 ^ INVERT;

    // The counter saturates at CNT_MAX only for the cycle that commits the new level.
    always_comb begin
        level_d   = level_q;
        count_d   = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (synced != level_q) begin
            if (count_q == CNT_MAX) begin
                level_d   = synced;
                press_d   = synced;
                release_d = ~synced;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q   <= 1'b0;
            count_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            count_q   <= count_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Board input conditioner: synchronises and debounces raw switches and buttons,
// presenting active-high levels plus press/release pulses to the core.
module io_input_conditioner #(
    parameter int SW_WIDTH        = 9,
    parameter int BTN_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [SW_WIDTH-1:0]  sw_raw_i,
    input  logic [BTN_WIDTH-1:0] btn_raw_i,
    output logic [SW_WIDTH-1:0]  sw_o,
    output logic [BTN_WIDTH-1:0] btn_o,
    output logic [BTN_WIDTH-1:0] btn_press_o,
    output logic [BTN_WIDTH-1:0] btn_release_o
);

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        io_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_PIN_LEVEL(1'b0),
            .INVERT         (1'b0)
        ) u_bit (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .pin_i    (sw_raw_i[i]),
            .level_o  (sw_o[i]),
            .press_o  (),
            .release_o()
        );
    end

    // Button synchronisers reset to the idle pin level so reset never looks like a press.
    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
        io_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_PIN_LEVEL(BTN_ACTIVE_LOW),
            .INVERT         (BTN_ACTIVE_LOW)
        ) u_bit (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .pin_i    (btn_raw_i[i]),
            .level_o  (btn_o[i]),
            .press_o  (btn_press_o[i]),
            .release_o(btn_release_o[i])
        );
    end

endmodule
